// File: rtl/positmult_stream_ctrl.sv
// Valid/ready stream wrapper around a fixed-latency posit multiplier with credit-based issue into an output FIFO.
// Optional pop statistics outputs when POSITMULT_STREAM_STATS_EN is defined.
module positmult_stream_ctrl #(
  parameter int DEPTH    = 8,
  parameter int MULT_LAT = 4,
  parameter int CW       = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_a,
  input  logic [31:0] in_b,
  output logic [31:0] mult_in1,
  output logic [31:0] mult_in2,
  output logic        mult_start,
  input  logic [31:0] mult_result,
  input  logic        mult_inf,
  input  logic        mult_zero,
  input  logic        mult_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_data,
  output logic        out_inf,
  output logic        out_zero
`ifdef POSITMULT_STREAM_STATS_EN
  ,
  output logic [31:0] stat_products,
  output logic [31:0] stat_inf,
  output logic [31:0] stat_zero
`endif
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {FLUSH, RUN} state_t;

  state_t        state, state_next;
  logic [CW-1:0] flush_cnt;
  logic [CW-1:0] count;
  logic [CW-1:0] inflight;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [33:0]   mem [DEPTH];
  logic [CW:0]   credit_sum;
  logic          issue;
  logic          push;
  logic          pop;

  // Stale products from before reset are dropped by gating push on RUN.
  always_comb begin
    state_next = state;
    if (state == FLUSH && flush_cnt == CW'(MULT_LAT - 1))
      state_next = RUN;
  end

  always_comb begin
    credit_sum = {1'b0, count} + {1'b0, inflight};
    in_ready   = (state == RUN) && (credit_sum < (CW + 1)'(DEPTH));
    issue      = in_valid & in_ready;
    push       = (state == RUN) & mult_done;
    out_valid  = (count != '0);
    pop        = out_valid & out_ready;
    mult_in1   = in_a;
    mult_in2   = in_b;
    mult_start = issue;
    out_data   = mem[rd_ptr][31:0];
    out_zero   = mem[rd_ptr][32];
    out_inf    = mem[rd_ptr][33];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= FLUSH;
      flush_cnt <= '0;
      count     <= '0;
      inflight  <= '0;
      rd_ptr    <= '0;
      wr_ptr    <= '0;
    end else begin
      state <= state_next;
      if (state == FLUSH)
        flush_cnt <= flush_cnt + 1'b1;
      case ({issue, push})
        2'b10:   inflight <= inflight + 1'b1;
        2'b01:   inflight <= inflight - 1'b1;
        default: inflight <= inflight;
      endcase
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= {mult_inf, mult_zero, mult_result};
  end

`ifdef POSITMULT_STREAM_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_products <= '0;
      stat_inf      <= '0;
      stat_zero     <= '0;
    end else if (pop) begin
      stat_products <= stat_products + 1'b1;
      if (out_inf)
        stat_inf <= stat_inf + 1'b1;
      if (out_zero)
        stat_zero <= stat_zero + 1'b1;
    end
  end
`endif

endmodule
